// File: rtl/axis_pkt_checker.sv
// ---------------------------------------------------------------------------
// axis_pkt_checker
//   Consumes an AXI-Stream packet flow and checks each packet against a
//   fixed framing: a header beat carrying a 32-bit sequence number and a
//   payload length, followed by L payload beats with a known data pattern.
//   tready is throttled by a free-running LFSR so the source sees
//   pseudo-random backpressure.
//
//   States:
//     HDR   | waiting for / checking the header beat of a packet
//     PAY   | checking payload beats 1..L
//     DRAIN | discarding surplus beats until tlast
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             1 = accept beats; 0 = tready held low
//   clear              pulse: zero counters and expected sequence number
//   stall_thresh       backpressure threshold (0 never stalls, >=128 always)
//   s_axis_t*          AXI-Stream slave (tdata, tuser, tkeep, tlast, tvalid,
//                      tready)
//   pkt_done           one-cycle pulse when a packet completes
//   err_valid          one-cycle pulse with pkt_done when the packet erred
//   err_code           {KEEP/USER, DATA, LEN, SEQ} flags of the last packet
//   pkt_count          saturating count of completed packets
//   err_count          saturating count of errored packets
// ---------------------------------------------------------------------------
module axis_pkt_checker #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned USER_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic [7:0]          stall_thresh,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [USER_W-1:0]   s_axis_tuser,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic                pkt_done,
    output logic                err_valid,
    output logic [3:0]          err_code,
    output logic [31:0]         pkt_count,
    output logic [31:0]         err_count
);

    localparam int unsigned KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        PAY   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [15:0]       lfsr;
    logic [15:0]       pay_idx, pay_idx_nxt;
    logic [15:0]       len_q, len_nxt;
    logic [31:0]       seq_exp;
    logic [31:0]       hdr_seq, hdr_seq_nxt;
    logic [USER_W-1:0] user_q, user_nxt;
    logic [3:0]        err_acc, err_acc_nxt;
    logic [3:0]        err_done;
    logic              complete;
    logic              seq_load;

    logic              fire;
    logic [15:0]       hdr_len;
    logic [KEEP_W-1:0] keep_inc;
    logic              keep_contig;
    logic              keep_bad;
    logic [DATA_W-1:0] pay_exp;
    logic [7:0]        lfsr_low;

    assign fire     = s_axis_tvalid & s_axis_tready;
    assign hdr_len  = s_axis_tdata[47:32];
    assign lfsr_low = {1'b0, lfsr[6:0]};

    // A mask is contiguous from the LSB exactly when adding one clears
    // every set bit (no set bit survives above the first zero).
    assign keep_inc    = s_axis_tkeep + KEEP_W'(1);
    assign keep_contig = ((s_axis_tkeep & keep_inc) == '0);
    assign keep_bad    = s_axis_tlast ? ((s_axis_tkeep == '0) || !keep_contig)
                                      : !(&s_axis_tkeep);

    // Expected payload beat: index in the low word, header sequence number
    // in the next word, zero above.
    always_comb begin
        pay_exp        = '0;
        pay_exp[31:0]  = {16'h0000, pay_idx};
        pay_exp[63:32] = hdr_seq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pay_idx_nxt = pay_idx;
        len_nxt     = len_q;
        hdr_seq_nxt = hdr_seq;
        user_nxt    = user_q;
        err_acc_nxt = err_acc;
        err_done    = '0;
        complete    = 1'b0;
        seq_load    = 1'b0;

        if (fire) begin
            unique case (state)
                HDR: begin
                    seq_load    = 1'b1;
                    hdr_seq_nxt = s_axis_tdata[31:0];
                    len_nxt     = hdr_len;
                    user_nxt    = s_axis_tuser;
                    pay_idx_nxt = 16'd1;
                    err_done    = {keep_bad, 2'b00, (s_axis_tdata[31:0] != seq_exp)};
                    if (s_axis_tlast) begin
                        err_done[1] = (hdr_len != 16'd0);
                        complete    = 1'b1;
                    end else if (hdr_len == 16'd0) begin
                        err_done[1] = 1'b1;
                        state_nxt   = DRAIN;
                    end else begin
                        state_nxt = PAY;
                    end
                    err_acc_nxt = err_done;
                end
                PAY: begin
                    err_done = err_acc;
                    if (s_axis_tdata != pay_exp) begin
                        err_done[2] = 1'b1;
                    end
                    if (keep_bad || (s_axis_tuser != user_q)) begin
                        err_done[3] = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (pay_idx != len_q) begin
                            err_done[1] = 1'b1;
                        end
                        complete = 1'b1;
                    end else if (pay_idx == len_q) begin
                        err_done[1] = 1'b1;
                        state_nxt   = DRAIN;
                    end else begin
                        pay_idx_nxt = pay_idx + 16'd1;
                    end
                    err_acc_nxt = err_done;
                end
                DRAIN: begin
                    err_done = err_acc;
                    if (s_axis_tlast) begin
                        complete = 1'b1;
                    end
                end
                default: begin
                    state_nxt = HDR;
                end
            endcase

            if (complete) begin
                state_nxt   = HDR;
                pay_idx_nxt = '0;
                err_acc_nxt = '0;
            end
        end
    end

    // Backpressure LFSR and registered tready.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr          <= LFSR_SEED;
            s_axis_tready <= 1'b0;
        end else begin
            lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            s_axis_tready <= enable & ~(lfsr_low < stall_thresh);
        end
    end

    // Per-packet context.
    always_ff @(posedge clk) begin
        if (rst) begin
            pay_idx <= '0;
            len_q   <= '0;
            hdr_seq <= '0;
            user_q  <= '0;
            err_acc <= '0;
        end else begin
            pay_idx <= pay_idx_nxt;
            len_q   <= len_nxt;
            hdr_seq <= hdr_seq_nxt;
            user_q  <= user_nxt;
            err_acc <= err_acc_nxt;
        end
    end

    // Completion reporting; clear overrides a coincident completion for the
    // counters and expected sequence number, but the pulses still fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_exp   <= '0;
            pkt_count <= '0;
            err_count <= '0;
            pkt_done  <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
        end else begin
            pkt_done  <= complete;
            err_valid <= complete & (|err_done);
            if (complete) begin
                err_code <= err_done;
            end

            if (clear) begin
                seq_exp <= '0;
            end else if (seq_load) begin
                seq_exp <= s_axis_tdata[31:0] + 32'd1;
            end

            if (clear) begin
                pkt_count <= '0;
                err_count <= '0;
            end else if (complete) begin
                if (pkt_count != '1) begin
                    pkt_count <= pkt_count + 32'd1;
                end
                if ((|err_done) && (err_count != '1)) begin
                    err_count <= err_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_checker
//   Scoreboard bench: each packet's expected err_code is derived from the
//   packet contents and pushed to a queue before it is driven; a monitor
//   pops and compares on every pkt_done.
// ---------------------------------------------------------------------------
module tb_axis_pkt_checker;

    localparam int DATA_W = 64;
    localparam int USER_W = 16;
    localparam int KEEP_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              clear;
    logic [7:0]        stall_thresh;
    logic [DATA_W-1:0] s_axis_tdata;
    logic [USER_W-1:0] s_axis_tuser;
    logic [KEEP_W-1:0] s_axis_tkeep;
    logic              s_axis_tlast;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              pkt_done;
    logic              err_valid;
    logic [3:0]        err_code;
    logic [31:0]       pkt_count;
    logic [31:0]       err_count;

    axis_pkt_checker #(
        .DATA_W   (DATA_W),
        .USER_W   (USER_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .stall_thresh (stall_thresh),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .pkt_done     (pkt_done),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .pkt_count    (pkt_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [USER_W-1:0] user;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    beat_t       pkt_q[$];
    logic [3:0]  exp_q[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] m_seq_exp = 0;
    logic [31:0] m_pkt = 0;
    logic [31:0] m_err = 0;
    bit          cnt_en  = 0;
    int          cyc_cnt = 0;
    int          low_cnt = 0;
    logic [3:0]  mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor and tready statistics.
    always @(negedge clk) begin
        if (pkt_done) begin
            check("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("err_code", 32'(err_code), 32'(mon_e));
                check("err_valid", 32'(err_valid), 32'(|mon_e));
            end
        end else if (err_valid) begin
            check("err_valid_without_done", 32'(pkt_done), 32'd1);
        end
        if (cnt_en) begin
            cyc_cnt++;
            if (!s_axis_tready) low_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DATA_W-1:0] exp_pay(input int k, input logic [31:0] sq);
        logic [DATA_W-1:0] d;
        d = '0;
        d[31:0]  = 32'(k);
        d[63:32] = sq;
        return d;
    endfunction

    function automatic bit keep_bad(input logic [KEEP_W-1:0] k, input logic last);
        int t = 0;
        if (!last) return (k != {KEEP_W{1'b1}});
        while (t < KEEP_W && k[t]) t++;
        return (t == 0) || (k != KEEP_W'((1 << t) - 1));
    endfunction

    // Header at index 0; payload beat k is checked only for k <= L.
    function automatic logic [3:0] model_err(input logic [31:0] seq_exp);
        logic [3:0]  e;
        logic [31:0] sq;
        int          n;
        int          len;
        e   = 4'b0000;
        n   = pkt_q.size();
        sq  = pkt_q[0].data[31:0];
        len = int'(pkt_q[0].data[47:32]);
        if (sq != seq_exp) e[0] = 1'b1;
        if (n - 1 != len) e[1] = 1'b1;
        for (int k = 0; k < n && k <= len; k++) begin
            if (keep_bad(pkt_q[k].keep, pkt_q[k].last)) e[3] = 1'b1;
            if (k > 0) begin
                if (pkt_q[k].user != pkt_q[0].user) e[3] = 1'b1;
                if (pkt_q[k].data != exp_pay(k, sq)) e[2] = 1'b1;
            end
        end
        return e;
    endfunction

    // ---------------- stimulus ----------------
    task automatic build_pkt(input logic [31:0] sq, input int len, input int n,
                             input logic [USER_W-1:0] user);
        beat_t b;
        pkt_q.delete();
        b.data         = '0;
        b.data[31:0]   = sq;
        b.data[47:32]  = 16'(len);
        b.user         = user;
        b.keep         = '1;
        b.last         = (n == 1);
        pkt_q.push_back(b);
        for (int k = 1; k < n; k++) begin
            b.data = exp_pay(k, sq);
            b.last = (k == n - 1);
            pkt_q.push_back(b);
        end
    endtask

    // Called just after a negedge; tready is stable until the next posedge,
    // so the handshake outcome is known when tvalid is chosen.
    task automatic send_beat(input beat_t b, input bit clr, input bit rnd_valid, input bit rnd_en);
        bit done = 0;
        int n    = 0;
        s_axis_tdata = b.data;
        s_axis_tuser = b.user;
        s_axis_tkeep = b.keep;
        s_axis_tlast = b.last;
        while (!done) begin
            if (rnd_en) enable = ($urandom_range(0, 99) < 80);
            s_axis_tvalid = rnd_valid ? ($urandom_range(0, 99) < 70) : 1'b1;
            done  = s_axis_tvalid && s_axis_tready;
            clear = clr && done;
            @(negedge clk);
            clear = 1'b0;
            n++;
            if (!done && n >= 4000) begin
                total++;
                $display("FAIL beat_accept_timeout: no handshake in %0d cycles, expected one", n);
                $display("%0d/%0d checks passed", passed, total);
                $fatal(1, "handshake timeout");
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input bit clr_last, input bit rnd_valid, input bit rnd_en);
        logic [3:0] e;
        e = model_err(m_seq_exp);
        m_seq_exp = pkt_q[0].data[31:0] + 32'd1;
        exp_q.push_back(e);
        if (clr_last) begin
            m_pkt = 0; m_err = 0; m_seq_exp = 0;
        end else begin
            m_pkt++;
            if (e != 0) m_err++;
        end
        for (int k = 0; k < pkt_q.size(); k++)
            send_beat(pkt_q[k], clr_last && (k == pkt_q.size() - 1), rnd_valid, rnd_en);
        enable = 1'b1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_pkt = 0; m_err = 0; m_seq_exp = 0;
    endtask

    task automatic check_counts(input string pname, input string ename);
        check(pname, pkt_count, m_pkt);
        check(ename, err_count, m_err);
    endtask

    initial begin
        int len;
        int n;
        int k;
        int pct;
        rst = 1'b1; enable = 1'b1; clear = 1'b0; stall_thresh = 8'd0;
        s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_tready", 32'(s_axis_tready), 32'd0);
        check("reset_pkt_done", 32'(pkt_done), 32'd0);
        check("reset_err_valid", 32'(err_valid), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_pkt_count", pkt_count, 32'd0);
        check("reset_err_count", err_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean stream, no backpressure.
        cnt_en = 1; cyc_cnt = 0; low_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            build_pkt(32'(s), s, s + 1, 16'($urandom()));
            send_pkt(0, 0, 0);
        end
        cnt_en = 0;
        check("nostall_tready_low_cycles", 32'(low_cnt), 32'd0);
        check_counts("clean_pkt_count", "clean_err_count");

        // Sequence mismatch then resync.
        pulse_clear();
        build_pkt(32'd5, 2, 3, 16'h00AA); send_pkt(0, 0, 0);
        build_pkt(32'd6, 1, 2, 16'h00BB); send_pkt(0, 0, 0);
        check_counts("seq_pkt_count", "seq_err_count");

        // Early tlast, late tlast with corrupt drained beats, then clean.
        build_pkt(32'd7, 3, 3, 16'h1111); send_pkt(0, 0, 0);
        build_pkt(32'd8, 3, 7, 16'h2222);
        pkt_q[5].data = pkt_q[5].data ^ 64'h1;
        pkt_q[5].keep = 8'h01;
        send_pkt(0, 0, 0);
        build_pkt(32'd9, 2, 3, 16'h3333); send_pkt(0, 0, 0);
        check_counts("len_pkt_count", "len_err_count");

        // DATA + KEEP error, clear coincident with completion.
        build_pkt(32'd10, 4, 5, 16'h4444);
        pkt_q[2].data = pkt_q[2].data ^ 64'h1;
        pkt_q[3].keep = 8'h7F;
        send_pkt(1, 0, 0);
        check_counts("clrdone_pkt_count", "clrdone_err_count");

        // Backpressure statistics with a withholding master.
        stall_thresh = 8'd77;
        cnt_en = 1; cyc_cnt = 0; low_cnt = 0;
        for (int s = 0; s < 200; s++) begin
            len = $urandom_range(0, 7);
            build_pkt(m_seq_exp, len, len + 1, 16'($urandom()));
            send_pkt(0, 1, 0);
        end
        cnt_en = 0;
        pct = (cyc_cnt > 0) ? (low_cnt * 100) / cyc_cnt : 0;
        check("stall77_pkt_count", pkt_count, 32'd200);
        check("stall77_err_count", err_count, 32'd0);
        if (!(pct >= 55 && pct <= 65))
            $display("tready low %0d%% over %0d cycles", pct, cyc_cnt);
        check("stall77_low_pct_in_55_65", 32'(pct >= 55 && pct <= 65), 32'd1);

        // Random packets with random faults and enable toggling.
        stall_thresh = 8'd30;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(0, 5);
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : len + 1;
            build_pkt(($urandom_range(0, 7) == 0) ? $urandom() : m_seq_exp,
                      len, n, 16'($urandom()));
            if (n > 1 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, n - 1);
                pkt_q[k].data = pkt_q[k].data ^ (64'h1 << $urandom_range(0, 63));
            end
            if (n > 1 && $urandom_range(0, 4) == 0) begin
                k = $urandom_range(1, n - 1);
                pkt_q[k].user = pkt_q[k].user ^ 16'h0100;
            end
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, n - 1);
                case ($urandom_range(0, 3))
                    0: pkt_q[k].keep = 8'h0F;
                    1: pkt_q[k].keep = 8'h05;
                    2: pkt_q[k].keep = 8'h00;
                    default: pkt_q[k].keep = 8'h7F;
                endcase
            end
            send_pkt(0, 1, 1);
        end
        check_counts("random_pkt_count", "random_err_count");

        // Reset mid-payload abandons the packet.
        stall_thresh = 8'd0;
        build_pkt(m_seq_exp, 3, 4, 16'h5555);
        send_beat(pkt_q[0], 0, 0, 0);
        send_beat(pkt_q[1], 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", 32'(s_axis_tready), 32'd0);
        check("midrst_pkt_count", pkt_count, 32'd0);
        rst = 1'b0;
        m_seq_exp = 0; m_pkt = 0; m_err = 0;
        build_pkt(32'd0, 2, 3, 16'h6666);
        send_pkt(0, 0, 0);
        repeat (2) @(negedge clk);
        check_counts("postrst_pkt_count", "postrst_err_count");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_pkt_checker.md
AXIS_PKT_CHECKER -- requirements
Module: axis_pkt_checker

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the tdata width in bits; legal values are 64 or larger, multiples of 8.
REQ-002 The block SHALL have parameter USER_W, default 16, giving the tuser width in bits.
REQ-003 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the nonzero backpressure LFSR reset value.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-005 enable  in  1  when 1, the checker accepts beats; when 0, tready is forced to 0.
REQ-006 clear  in  1  sync pulse; zeroes the counters and the expected sequence number.
REQ-007 stall_thresh  in  8  backpressure threshold: 0 means never stall; 128 or more means always stall.
REQ-008 s_axis_tdata  in  DATA_W  stream data.
REQ-009 s_axis_tuser  in  USER_W  stream user sideband.
REQ-010 s_axis_tkeep  in  DATA_W/8  byte enables.
REQ-011 s_axis_tlast, s_axis_tvalid  in  1 each  end of packet and valid.
REQ-012 s_axis_tready  out  1  ready.
REQ-013 pkt_done  out  1  one-cycle pulse when a packet's final beat is accepted.
REQ-014 err_valid  out  1  one-cycle pulse, coincident with pkt_done, when the packet had any error.
REQ-015 err_code  out  4  error flags for the packet just done: [0] SEQ, [1] LEN, [2] DATA, [3] KEEP/USER.
REQ-016 pkt_count, err_count  out  32 each  saturating counts of completed packets and errored packets.

Function
REQ-017 A beat SHALL transfer only on a clk edge where tvalid and tready are both 1; tready SHALL NOT depend combinationally on tvalid.
REQ-018 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL load LFSR_SEED on reset and advance every cycle, independent of the handshake.
REQ-019 tready SHALL be registered and SHALL equal enable AND NOT (lfsr[6:0] < stall_thresh), using values from the previous cycle.
REQ-020 The first beat of a packet is the header: tdata[31:0] is the sequence number and tdata[47:32] is the payload length L in beats after the header.
REQ-021 The header SHALL set SEQ if tdata[31:0] differs from seq_exp; seq_exp SHALL then become tdata[31:0]+1 mod 2^32, resyncing after a mismatch.
REQ-022 Payload beat i (for i from 1 to L) SHALL set DATA if tdata differs from the zero-extended i, or from its 32-bit sequence copy in bits [63:32].
REQ-023 The checker SHALL latch tuser on the header; any later beat whose tuser differs SHALL set bit 3.
REQ-024 Every non-last beat SHALL set bit 3 if tkeep is not all ones.
REQ-025 The last beat SHALL set bit 3 if tkeep is zero or not contiguous from the LSB.
REQ-026 The state machine SHALL have three states: HDR (reset state), PAY and DRAIN.
REQ-027 From HDR, a header beat with tlast SHALL complete the packet when L=0, and SHALL complete it with LEN set when L>0; a header beat without tlast SHALL go to PAY when L>0, and SHALL go to DRAIN with LEN set when L=0.
REQ-028 In PAY, tlast with i<L SHALL set LEN and complete the packet.
REQ-029 In PAY, tlast with i=L SHALL complete the packet.
REQ-030 In PAY, beat i=L without tlast SHALL set LEN and go to DRAIN.
REQ-031 DRAIN SHALL discard beats without further checks until tlast, then complete the packet.
REQ-032 On completion, the FSM SHALL return to HDR and pulse pkt_done; it SHALL also pulse err_valid when err_code is nonzero.
REQ-033 err_code SHALL hold its value until the next completion.
REQ-034 On completion, pkt_count SHALL increment, and err_count SHALL increment on error; both SHALL saturate at 2^32-1 with no wrap.
REQ-035 If clear coincides with a completion, clear SHALL win: counters and seq_exp go to 0, and pkt_done/err_valid still pulse.
REQ-036 Deasserting enable mid-packet SHALL hold the FSM state, beat index and error accumulators; checking resumes when enable returns.
REQ-037 The payload beat index SHALL be 16 bits wide; L=65535 SHALL be legal and SHALL NOT wrap.

Reset
REQ-038 While rst is 1, tready, pkt_done, err_valid, err_code, pkt_count, err_count, seq_exp and the beat index SHALL be 0, the FSM SHALL be in HDR, and the LFSR SHALL hold LFSR_SEED.
REQ-039 Asserting rst mid-packet SHALL abandon the packet with no completion pulse; the first beat after reset SHALL be treated as a header.

Verification
REQ-040 stall_thresh=0, enable=1, seq 0..9 with L=0..9, correct data -> tready held at 1, pkt_count=10, err_count=0, no err_valid.
REQ-041 stall_thresh=77, master randomly withholds tvalid, 200 packets -> pkt_count=200, err_count=0, and the tready-low fraction is about 60% ±5%.
REQ-042 seq 5 sent when seq_exp=0, then seq 6 -> first packet err_code=4'b0001; second packet clean; err_count=1.
REQ-043 L=3 with tlast on beat 2 -> LEN; L=3 with tlast on beat 6 -> LEN, beats 4-6 drained, and the next header is checked normally.
REQ-044 Payload beat 2 tdata corrupted, plus a non-last beat with tkeep=8'h7F -> err_code=4'b1100; then clear coincident with completion -> counters read 0.
REQ-045 rst asserted for 1 cycle mid-payload -> no completion pulse; a following seq-0 packet passes with pkt_count=1.
